// File: rtl/traffic_phase_controller_pkg.sv
// Shared definitions for the four-way traffic phase controller.
// State encodings, lamp bit positions and a sizing helper.
package traffic_phase_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_NS_GREEN  = 3'd0;
  localparam state_t S_NS_YELLOW = 3'd1;
  localparam state_t S_ALLRED_A  = 3'd2;
  localparam state_t S_EW_GREEN  = 3'd3;
  localparam state_t S_EW_YELLOW = 3'd4;
  localparam state_t S_ALLRED_B  = 3'd5;
  localparam state_t S_FLASH     = 3'd6;

  localparam int N_R = 0;
  localparam int N_Y = 1;
  localparam int N_G = 2;
  localparam int E_R = 3;
  localparam int E_Y = 4;
  localparam int E_G = 5;
  localparam int S_R = 6;
  localparam int S_Y = 7;
  localparam int S_G = 8;
  localparam int W_R = 9;
  localparam int W_Y = 10;
  localparam int W_G = 11;

  localparam logic [11:0] LAMPS_RED = 12'h249;
  localparam logic [11:0] LAMPS_YEL = 12'h492;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Sensor inputs, lamp outputs and phase debug bus.
// The controller side is the master.
interface traffic_phase_controller_if;
  logic       ew_req;
  logic       flash_req;
  logic       N_red, N_yellow, N_green;
  logic       E_red, E_yellow, E_green;
  logic       S_red, S_yellow, S_green;
  logic       W_red, W_yellow, W_green;
  logic [2:0] phase;

  modport master (
    input  ew_req, flash_req,
    output N_red, N_yellow, N_green,
    output E_red, E_yellow, E_green,
    output S_red, S_yellow, S_green,
    output W_red, W_yellow, W_green,
    output phase
  );

  modport slave (
    output ew_req, flash_req,
    input  N_red, N_yellow, N_green,
    input  E_red, E_yellow, E_green,
    input  S_red, S_yellow, S_green,
    input  W_red, W_yellow, W_green,
    input  phase
  );
endinterface

// File: rtl/traffic_phase_controller_tick_prescaler.sv
// Divides clk down to a one-cycle timing tick.
// Count runs 0..DIV-1; tick is high while the count sits at DIV-1.
module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Free-running counter, wraps after the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Four-way intersection phase FSM with E/W demand and flash mode.
// Lamps are registered alongside the state so they change together.
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2
) (
  input logic clk,
  input logic rst_n,
  traffic_phase_controller_if.master bus
);

  localparam int MAXD = max3(GREEN_T, YELLOW_T, ALLRED_T);
  localparam int RW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  localparam logic [RW-1:0] G_LD = RW'(GREEN_T - 1);
  localparam logic [RW-1:0] Y_LD = RW'(YELLOW_T - 1);
  localparam logic [RW-1:0] A_LD = RW'(ALLRED_T - 1);

  logic          tick;
  logic          expire;
  state_t        state, state_d;
  logic [RW-1:0] remain, remain_d;
  logic          pend, pend_d;
  logic          blink, blink_d;
  logic [11:0]   lamp_q, lamp_d;

  tick_prescaler #(.DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign expire = tick & (remain == '0);

  // State, timers and registered lamp outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_ALLRED_B;
      remain <= A_LD;
      pend   <= 1'b0;
      blink  <= 1'b0;
      lamp_q <= LAMPS_RED;
    end else begin
      state  <= state_d;
      remain <= remain_d;
      pend   <= pend_d;
      blink  <= blink_d;
      lamp_q <= lamp_d;
    end
  end

  // Next state: flash request beats phase expiry
  always_comb begin
    state_d  = state;
    remain_d = remain;
    blink_d  = blink;
    pend_d   = pend | bus.ew_req;
    if (tick && remain != '0) remain_d = remain - 1'b1;
    if (tick && bus.flash_req) begin
      state_d = S_FLASH;
      blink_d = (state == S_FLASH) ? ~blink : 1'b1;
    end else if (state == S_FLASH) begin
      if (tick) begin
        state_d  = S_ALLRED_B;
        remain_d = A_LD;
        blink_d  = 1'b0;
      end
    end else if (expire) begin
      case (state)
        S_ALLRED_B: begin
          state_d  = S_NS_GREEN;
          remain_d = G_LD;
        end
        S_NS_GREEN: begin
          if (pend) begin
            state_d  = S_NS_YELLOW;
            remain_d = Y_LD;
          end
        end
        S_NS_YELLOW: begin
          state_d  = S_ALLRED_A;
          remain_d = A_LD;
        end
        S_ALLRED_A: begin
          state_d  = S_EW_GREEN;
          remain_d = G_LD;
          pend_d   = 1'b0;
        end
        S_EW_GREEN: begin
          state_d  = S_EW_YELLOW;
          remain_d = Y_LD;
        end
        S_EW_YELLOW: begin
          state_d  = S_ALLRED_B;
          remain_d = A_LD;
        end
        default: state_d = S_ALLRED_B;
      endcase
    end
  end

  // Lamp decode of the upcoming state
  always_comb begin
    lamp_d = LAMPS_RED;
    unique case (1'b1)
      state_d == S_NS_GREEN: begin
        lamp_d[N_R] = 1'b0;
        lamp_d[N_G] = 1'b1;
        lamp_d[S_R] = 1'b0;
        lamp_d[S_G] = 1'b1;
      end
      state_d == S_NS_YELLOW: begin
        lamp_d[N_R] = 1'b0;
        lamp_d[N_Y] = 1'b1;
        lamp_d[S_R] = 1'b0;
        lamp_d[S_Y] = 1'b1;
      end
      state_d == S_EW_GREEN: begin
        lamp_d[E_R] = 1'b0;
        lamp_d[E_G] = 1'b1;
        lamp_d[W_R] = 1'b0;
        lamp_d[W_G] = 1'b1;
      end
      state_d == S_EW_YELLOW: begin
        lamp_d[E_R] = 1'b0;
        lamp_d[E_Y] = 1'b1;
        lamp_d[W_R] = 1'b0;
        lamp_d[W_Y] = 1'b1;
      end
      state_d == S_FLASH: begin
        lamp_d = blink_d ? LAMPS_YEL : 12'h000;
      end
      default: lamp_d = LAMPS_RED;
    endcase
  end

  assign bus.N_red    = lamp_q[N_R];
  assign bus.N_yellow = lamp_q[N_Y];
  assign bus.N_green  = lamp_q[N_G];
  assign bus.E_red    = lamp_q[E_R];
  assign bus.E_yellow = lamp_q[E_Y];
  assign bus.E_green  = lamp_q[E_G];
  assign bus.S_red    = lamp_q[S_R];
  assign bus.S_yellow = lamp_q[S_Y];
  assign bus.S_green  = lamp_q[S_G];
  assign bus.W_red    = lamp_q[W_R];
  assign bus.W_yellow = lamp_q[W_Y];
  assign bus.W_green  = lamp_q[W_G];
  assign bus.phase    = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller.
// Small timing parameters; edges counted from reset release.
module tb_traffic_phase_controller;
  import traffic_phase_controller_pkg::*;

  // Lamp pattern packed as N,E,S,W each {red,yellow,green}
  localparam logic [11:0] ALLRED = 12'b100_100_100_100;
  localparam logic [11:0] NSG    = 12'b001_100_001_100;
  localparam logic [11:0] NSY    = 12'b010_100_010_100;
  localparam logic [11:0] EWG    = 12'b100_001_100_001;
  localparam logic [11:0] EWY    = 12'b100_010_100_010;
  localparam logic [11:0] FLY    = 12'b010_010_010_010;
  localparam logic [11:0] FLO    = 12'b000_000_000_000;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   edge_cnt;

  traffic_phase_controller_if bus ();

  traffic_phase_controller #(
    .TICK_DIV (4),
    .GREEN_T  (3),
    .YELLOW_T (1),
    .ALLRED_T (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [11:0] lamps;
  assign lamps = {bus.N_red, bus.N_yellow, bus.N_green,
                  bus.E_red, bus.E_yellow, bus.E_green,
                  bus.S_red, bus.S_yellow, bus.S_green,
                  bus.W_red, bus.W_yellow, bus.W_green};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] el,
                     input logic [2:0] ep);
    compared++;
    assert ({lamps, bus.phase} === {el, ep}) else begin
      mismatched++;
      $error("FAIL %s: observed lamps=%b phase=%0d expected lamps=%b phase=%0d",
             tag, lamps, bus.phase, el, ep);
    end
  endtask

  task automatic inv_chk();
    logic ok;
    ok = ($countones(lamps[11:9]) == 1) && ($countones(lamps[8:6]) == 1) &&
         ($countones(lamps[5:3]) == 1) && ($countones(lamps[2:0]) == 1) &&
         !((lamps[9] | lamps[3]) & (lamps[6] | lamps[0]));
    compared++;
    assert (ok === 1'b1) else begin
      mismatched++;
      $error("FAIL invariant@%0d: observed lamps=%b expected one lamp per dir, no cross green",
             edge_cnt, lamps);
    end
  endtask

  task automatic goto(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (bus.phase != S_FLASH) inv_chk();
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk(tag, ALLRED, S_ALLRED_B);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    edge_cnt     = 0;
    rst_n        = 1'b0;
    bus.ew_req    = 1'b0;
    bus.flash_req = 1'b0;

    @(posedge clk);
    #1;
    chk("reset", ALLRED, S_ALLRED_B);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    goto(3);  chk("s1_e3_allred", ALLRED, S_ALLRED_B);
    goto(4);  chk("s1_e4_nsg", NSG, S_NS_GREEN);
    goto(20); chk("s1_e20_nsg", NSG, S_NS_GREEN);
    goto(48); chk("s1_e48_nsg_hold", NSG, S_NS_GREEN);

    async_reset("s2_async_reset");
    goto(5);  bus.ew_req = 1'b1;
    goto(6);  bus.ew_req = 1'b0;
    goto(15); chk("s2_e15_nsg", NSG, S_NS_GREEN);
    goto(16); chk("s2_e16_nsy", NSY, S_NS_YELLOW);
    goto(19); chk("s2_e19_nsy", NSY, S_NS_YELLOW);
    goto(20); chk("s2_e20_ara", ALLRED, S_ALLRED_A);
    goto(23); chk("s2_e23_ara", ALLRED, S_ALLRED_A);
    goto(24); chk("s2_e24_ewg", EWG, S_EW_GREEN);
    goto(35); chk("s2_e35_ewg", EWG, S_EW_GREEN);
    goto(36); chk("s2_e36_ewy", EWY, S_EW_YELLOW);
    goto(40); chk("s2_e40_arb", ALLRED, S_ALLRED_B);
    goto(43); chk("s2_e43_arb", ALLRED, S_ALLRED_B);
    goto(44); chk("s2_e44_nsg", NSG, S_NS_GREEN);
    goto(60); chk("s2_e60_pend_clr", NSG, S_NS_GREEN);

    bus.ew_req = 1'b1;
    goto(64);  chk("s3_e64_nsy", NSY, S_NS_YELLOW);
    goto(68);  chk("s3_e68_ara", ALLRED, S_ALLRED_A);
    goto(72);  chk("s3_e72_ewg", EWG, S_EW_GREEN);
    goto(92);  chk("s3_e92_nsg", NSG, S_NS_GREEN);
    goto(103); chk("s3_e103_nsg", NSG, S_NS_GREEN);
    goto(104); chk("s3_e104_nsy", NSY, S_NS_YELLOW);
    goto(112); chk("s3_e112_ewg", EWG, S_EW_GREEN);

    goto(113);
    bus.flash_req = 1'b1;
    bus.ew_req    = 1'b0;
    goto(115); chk("s4_e115_ewg", EWG, S_EW_GREEN);
    goto(116); chk("s4_e116_fly", FLY, S_FLASH);
    goto(119); chk("s4_e119_fly", FLY, S_FLASH);
    goto(120); chk("s4_e120_flo", FLO, S_FLASH);
    goto(124); chk("s4_e124_fly", FLY, S_FLASH);
    goto(128); chk("s4_e128_flo", FLO, S_FLASH);
    goto(129);
    bus.flash_req = 1'b0;
    goto(131); chk("s4_e131_flo", FLO, S_FLASH);
    goto(132); chk("s4_e132_arb", ALLRED, S_ALLRED_B);
    goto(135); chk("s4_e135_arb", ALLRED, S_ALLRED_B);
    goto(136); chk("s4_e136_nsg", NSG, S_NS_GREEN);
    goto(148); chk("s4_e148_nsy", NSY, S_NS_YELLOW);

    goto(149);
    async_reset("s5_async_reset");
    goto(3);  chk("s5_e3_allred", ALLRED, S_ALLRED_B);
    goto(4);  chk("s5_e4_nsg", NSG, S_NS_GREEN);
    goto(16); chk("s5_e16_nsg_nopend", NSG, S_NS_GREEN);
    goto(44); chk("s5_e44_nsg_hold", NSG, S_NS_GREEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
